// File: rtl/pill_line_feeder.sv
// pill_line_feeder: pill dispenser and bottle conveyor sequencer.
//
// Automatic pills are dispensed every PILL_PERIOD cycles while feeding. Each
// bottle request moves the conveyor for MOVE_TIME running cycles, and faults
// if the move takes MOVE_TIMEOUT cycles in total.
//
// Optional feature: define HOPPER_MANUAL_EN to enable the manual pill button
// (hopper_add). Without it, hopper_add is ignored and the edge/deferral logic
// is not built.
//
// Ports:
//   clk_1khz       in   sole clock, rising edge
//   switch_clr     in   synchronous active-high reset
//   run            in   controller is filling; enables automatic feeding
//   hopper_stop    in   hopper empty; holds the pill timer
//   hopper_add     in   manual pill button (level, unsynchronised)
//   conveyor_stop  in   conveyor halted; freezes bottle movement
//   bottle_req     in   request for the next bottle
//   pill_pulse     out  one-cycle pulse per dispensed pill
//   pill_count     out  pills in the current bottle, saturating at 999
//   bottle_ready   out  one-cycle pulse when the next bottle is in position
//   conveyor_busy  out  high while moving a bottle
//   fault          out  high while faulted (cleared only by switch_clr)
module pill_line_feeder #(
    parameter int unsigned PILL_PERIOD  = 1000,
    parameter int unsigned MOVE_TIME    = 2000,
    parameter int unsigned MOVE_TIMEOUT = 4000
) (
    input  logic       clk_1khz,
    input  logic       switch_clr,
    input  logic       run,
    input  logic       hopper_stop,
    input  logic       hopper_add,
    input  logic       conveyor_stop,
    input  logic       bottle_req,
    output logic       pill_pulse,
    output logic [9:0] pill_count,
    output logic       bottle_ready,
    output logic       conveyor_busy,
    output logic       fault
);

    localparam int unsigned PillW = (PILL_PERIOD > 1) ? $clog2(PILL_PERIOD) : 1;
    localparam int unsigned MoveW = (MOVE_TIME > 1) ? $clog2(MOVE_TIME) : 1;
    localparam int unsigned TmoW  = (MOVE_TIMEOUT > 1) ? $clog2(MOVE_TIMEOUT) : 1;

    localparam logic [PillW-1:0] PillLast = PillW'(PILL_PERIOD - 1);
    localparam logic [MoveW-1:0] MoveLoad = MoveW'(MOVE_TIME - 1);
    localparam logic [TmoW-1:0]  TmoLast  = TmoW'(MOVE_TIMEOUT - 1);
    localparam logic [9:0]       CountMax = 10'd999;

    typedef enum logic [1:0] {StIdle, StFeed, StMove, StFault} state_e;

    state_e             state_q, state_d;
    logic [PillW-1:0]   pill_timer_q, pill_timer_d;
    logic [MoveW-1:0]   move_cnt_q, move_cnt_d;
    logic [TmoW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic               pill_pulse_q, pill_pulse_d;
    logic [9:0]         pill_count_q, pill_count_d;
    logic               bottle_ready_q, bottle_ready_d;

    logic can_take;     // states that accept bottle requests and manual pills
    logic auto_fire;
    logic manual_fire;
    logic defer_fire;
    logic bottle_go;
    logic move_done;
    logic move_tmo;

    assign can_take  = (state_q == StIdle) || (state_q == StFeed);
    assign auto_fire = (state_q == StFeed) && !hopper_stop && (pill_timer_q == PillLast);
    assign bottle_go = can_take && bottle_req;
    assign move_done = (state_q == StMove) && (move_cnt_q == '0) && !conveyor_stop;
    assign move_tmo  = (state_q == StMove) && (tmo_cnt_q == TmoLast);

`ifdef HOPPER_MANUAL_EN
    logic add_prev_q;
    logic defer_q, defer_d;
    logic add_edge;

    assign add_edge    = hopper_add && !add_prev_q && can_take;
    // A manual pill landing on an automatic pill slips one cycle.
    assign manual_fire = add_edge && !auto_fire;
    assign defer_d     = add_edge && auto_fire;
    assign defer_fire  = defer_q;

    always_ff @(posedge clk_1khz) begin
        if (switch_clr) begin
            add_prev_q <= 1'b0;
            defer_q    <= 1'b0;
        end else begin
            add_prev_q <= hopper_add;
            defer_q    <= defer_d;
        end
    end
`else
    logic unused_hopper_add;

    assign unused_hopper_add = hopper_add;
    assign manual_fire       = 1'b0;
    assign defer_fire        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_1khz) begin
        if (switch_clr) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (bottle_req) begin
                    state_d = StMove;
                end else if (run) begin
                    state_d = StFeed;
                end
            end
            StFeed: begin
                if (bottle_req) begin
                    state_d = StMove;
                end else if (!run) begin
                    state_d = StIdle;
                end
            end
            StMove: begin
                // Completion wins over a simultaneous timeout.
                if (move_done) begin
                    state_d = run ? StFeed : StIdle;
                end else if (move_tmo) begin
                    state_d = StFault;
                end
            end
            StFault: state_d = StFault;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        pill_pulse_d   = auto_fire || manual_fire || defer_fire;
        bottle_ready_d = move_done;

        // Timer runs only while staying in FEED; any exit clears it.
        pill_timer_d = '0;
        if ((state_q == StFeed) && (state_d == StFeed)) begin
            if (hopper_stop) begin
                pill_timer_d = pill_timer_q;
            end else if (pill_timer_q == PillLast) begin
                pill_timer_d = '0;
            end else begin
                pill_timer_d = pill_timer_q + 1'b1;
            end
        end

        pill_count_d = pill_count_q;
        if (bottle_go) begin
            pill_count_d = '0;
        end else if (pill_pulse_d && (pill_count_q != CountMax)) begin
            pill_count_d = pill_count_q + 1'b1;
        end

        move_cnt_d = move_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        if (bottle_go) begin
            move_cnt_d = MoveLoad;
            tmo_cnt_d  = '0;
        end else if (state_q == StMove) begin
            if (!conveyor_stop && (move_cnt_q != '0)) begin
                move_cnt_d = move_cnt_q - 1'b1;
            end
            if (tmo_cnt_q != TmoLast) begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_1khz) begin
        if (switch_clr) begin
            pill_timer_q   <= '0;
            move_cnt_q     <= '0;
            tmo_cnt_q      <= '0;
            pill_pulse_q   <= 1'b0;
            pill_count_q   <= '0;
            bottle_ready_q <= 1'b0;
        end else begin
            pill_timer_q   <= pill_timer_d;
            move_cnt_q     <= move_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            pill_pulse_q   <= pill_pulse_d;
            pill_count_q   <= pill_count_d;
            bottle_ready_q <= bottle_ready_d;
        end
    end

    // Outputs
    always_comb begin
        pill_pulse    = pill_pulse_q;
        pill_count    = pill_count_q;
        bottle_ready  = bottle_ready_q;
        conveyor_busy = (state_q == StMove);
        fault         = (state_q == StFault);
    end

endmodule

// File: tb/tb_pill_line_feeder.sv
// Randomised bench for pill_line_feeder against a cycle-level reference model
// derived from the pill/bottle rules. Works with and without HOPPER_MANUAL_EN.
module tb_pill_line_feeder;

    localparam int PP = 4;
    localparam int MT = 5;
    localparam int TO = 8;
`ifdef HOPPER_MANUAL_EN
    localparam bit ManualEn = 1'b1;
`else
    localparam bit ManualEn = 1'b0;
`endif

    localparam int ModeIdle  = 0;
    localparam int ModeFeed  = 1;
    localparam int ModeMove  = 2;
    localparam int ModeFault = 3;

    logic       clk_1khz = 1'b0;
    logic       switch_clr = 1'b1;
    logic       run = 1'b0;
    logic       hopper_stop = 1'b0;
    logic       hopper_add = 1'b0;
    logic       conveyor_stop = 1'b0;
    logic       bottle_req = 1'b0;
    logic       pill_pulse;
    logic [9:0] pill_count;
    logic       bottle_ready;
    logic       conveyor_busy;
    logic       fault;

    pill_line_feeder #(
        .PILL_PERIOD  (PP),
        .MOVE_TIME    (MT),
        .MOVE_TIMEOUT (TO)
    ) dut (
        .clk_1khz      (clk_1khz),
        .switch_clr    (switch_clr),
        .run           (run),
        .hopper_stop   (hopper_stop),
        .hopper_add    (hopper_add),
        .conveyor_stop (conveyor_stop),
        .bottle_req    (bottle_req),
        .pill_pulse    (pill_pulse),
        .pill_count    (pill_count),
        .bottle_ready  (bottle_ready),
        .conveyor_busy (conveyor_busy),
        .fault         (fault)
    );

    always #5 clk_1khz = ~clk_1khz;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: what the line should show after the next clock edge.
    int m_mode     = ModeIdle;
    int m_timer    = 0;     // cycles elapsed in the current pill period
    int m_progress = 0;     // running cycles completed on the current move
    int m_elapsed  = 0;     // total cycles spent on the current move
    int m_count    = 0;
    bit m_prev_add = 1'b0;
    bit m_owed     = 1'b0;  // manual pill postponed behind an automatic one
    bit m_pulse    = 1'b0;
    bit m_ready    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: observed %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step();
        bit auto_pill, manual_pill, take_bottle, arrived, timed_out;
        int next_mode;
        if (switch_clr) begin
            m_mode = ModeIdle; m_timer = 0; m_progress = 0; m_elapsed = 0;
            m_count = 0; m_prev_add = 1'b0; m_owed = 1'b0; m_pulse = 1'b0;
            m_ready = 1'b0;
            return;
        end
        auto_pill   = (m_mode == ModeFeed) && !hopper_stop && (m_timer == PP - 1);
        manual_pill = ManualEn && hopper_add && !m_prev_add &&
                      (m_mode == ModeIdle || m_mode == ModeFeed);
        take_bottle = bottle_req && (m_mode == ModeIdle || m_mode == ModeFeed);
        arrived     = (m_mode == ModeMove) && (m_progress == MT - 1) && !conveyor_stop;
        timed_out   = (m_mode == ModeMove) && (m_elapsed == TO - 1);

        next_mode = m_mode;
        if (take_bottle) next_mode = ModeMove;
        else if (m_mode == ModeIdle && run) next_mode = ModeFeed;
        else if (m_mode == ModeFeed && !run) next_mode = ModeIdle;
        else if (arrived) next_mode = run ? ModeFeed : ModeIdle;
        else if (timed_out) next_mode = ModeFault;

        m_pulse = auto_pill || m_owed || (manual_pill && !auto_pill);
        m_owed  = manual_pill && auto_pill;

        if (take_bottle) m_count = 0;
        else if (m_pulse && m_count < 999) m_count = m_count + 1;

        if (m_mode == ModeFeed && next_mode == ModeFeed) begin
            if (!hopper_stop) m_timer = (m_timer + 1) % PP;
        end else begin
            m_timer = 0;
        end

        if (take_bottle) begin
            m_progress = 0;
            m_elapsed  = 0;
        end else if (m_mode == ModeMove) begin
            if (!conveyor_stop && m_progress < MT - 1) m_progress++;
            m_elapsed++;
        end

        m_ready    = arrived;
        m_prev_add = hopper_add;
        m_mode     = next_mode;
    endtask

    task automatic compare_outputs();
        check("pill_pulse", 32'(pill_pulse), 32'(m_pulse));
        check("pill_count", 32'(pill_count), 32'(m_count));
        check("bottle_ready", 32'(bottle_ready), 32'(m_ready));
        check("conveyor_busy", 32'(conveyor_busy), 32'(m_mode == ModeMove));
        check("fault", 32'(fault), 32'(m_mode == ModeFault));
    endtask

    // Phase 0: general random traffic. Phase 1: long fill to reach saturation.
    task automatic pick_inputs(input int phase);
        if (phase == 0) begin
            if (cyc < 3) switch_clr = 1'b1;
            else if (m_mode == ModeFault) switch_clr = ($urandom_range(0, 7) == 0);
            else switch_clr = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 29) == 0) run = ~run;
            if ($urandom_range(0, 14) == 0) hopper_stop = ~hopper_stop;
            if ($urandom_range(0, 3) == 0) hopper_add = ~hopper_add;
            if ($urandom_range(0, 11) == 0) conveyor_stop = ~conveyor_stop;
            bottle_req = ($urandom_range(0, 39) == 0);
        end else begin
            switch_clr    = (m_mode == ModeFault);
            run           = 1'b1;
            hopper_stop   = 1'b0;
            hopper_add    = ~hopper_add;
            conveyor_stop = 1'b0;
            bottle_req    = 1'b0;
        end
    endtask

    initial begin
        pick_inputs(0);
        model_step();
        for (int i = 0; i < 8500; i++) begin
            @(posedge clk_1khz);
            @(negedge clk_1khz);
            cyc++;
            compare_outputs();
            pick_inputs((i < 4000) ? 0 : 1);
            model_step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
